// File: rtl/riscv_commit_checker.sv
// In-order retirement checker: compares retired writebacks against a preloaded queue (RISCV_CHECKER_PC_CHECK_EN adds a PC match).
// Latency: counters, capture registers and done/pass/fail are visible one cycle after the deciding edge.
// Backpressure: exp_ready_o drops when the queue is full or the checker has left IDLE; wb port has none.
module riscv_commit_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     exp_valid_i,
  output logic                     exp_ready_o,
  input  logic [4:0]               exp_rd_i,
  input  logic [DATA_WIDTH-1:0]    exp_data_i,
  input  logic [DATA_WIDTH-1:0]    exp_pc_i,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  input  logic [DATA_WIDTH-1:0]    wb_pc_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         pass_count_o,
  output logic [CNT_W-1:0]         fail_count_o,
  output logic [CNT_W-1:0]         cycle_count_o,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx_o,
  output logic [DATA_WIDTH-1:0]    first_fail_data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [IDX_W-1:0]  ff_idx_q, ff_idx_d;
  logic [DATA_WIDTH-1:0] ff_data_q, ff_data_d;

  // Queue is only written in IDLE and only read in RUN, so plain counters replace a ring buffer.
  logic [4:0]            rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
`ifdef RISCV_CHECKER_PC_CHECK_EN
  logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
`endif

  logic             full;
  logic             load_fire;
  logic             wb_evt;
  logic             match;
  logic             last_pop;
  logic [IDX_W-1:0] head_idx;
  logic [WD_W-1:0]  wd_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full      = (wr_cnt_q == DEPTH_P);
  assign load_fire = (state_q == S_IDLE) && exp_valid_i && !full;
  assign wb_evt    = (state_q == S_RUN) && wb_valid_i && (wb_rd_i != 5'd0);
  assign head_idx  = rd_ptr_q[IDX_W-1:0];
  assign last_pop  = ((rd_ptr_q + PTR_W'(1)) == wr_cnt_q);
  assign wd_inc    = wd_q + WD_W'(1);

`ifdef RISCV_CHECKER_PC_CHECK_EN
  assign match = (wb_rd_i == rd_mem[head_idx]) && (wb_data_i == data_mem[head_idx]) &&
                 (wb_pc_i == pc_mem[head_idx]);
`else
  logic unused_pc;
  assign unused_pc = ^{exp_pc_i, wb_pc_i};
  assign match = (wb_rd_i == rd_mem[head_idx]) && (wb_data_i == data_mem[head_idx]);
`endif

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    wd_d       = wd_q;
    ff_idx_d   = ff_idx_q;
    ff_data_d  = ff_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (load_fire) wr_cnt_d = wr_cnt_q + PTR_W'(1);
        if (start_i) begin
          wd_d    = '0;
          state_d = ((wr_cnt_q != '0) || load_fire) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        cyc_cnt_d = sat_inc(cyc_cnt_q);
        if (wb_evt) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          wd_d     = '0;
          if (match) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            // fail count saturates and never wraps to zero, so zero means "no fail yet"
            if (fail_cnt_q == '0) begin
              ff_idx_d  = head_idx;
              ff_data_d = wb_data_i;
            end
          end
          if (last_pop) state_d = S_DONE;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WD_LIMIT) state_d = S_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (clear_i) begin
      state_d    = S_IDLE;
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      cyc_cnt_d  = '0;
      wd_d       = '0;
      ff_idx_d   = '0;
      ff_data_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      wd_q       <= '0;
      ff_idx_q   <= '0;
      ff_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      wd_q       <= wd_d;
      ff_idx_q   <= ff_idx_d;
      ff_data_q  <= ff_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_fire) begin
      rd_mem[wr_cnt_q[IDX_W-1:0]]   <= exp_rd_i;
      data_mem[wr_cnt_q[IDX_W-1:0]] <= exp_data_i;
`ifdef RISCV_CHECKER_PC_CHECK_EN
      pc_mem[wr_cnt_q[IDX_W-1:0]]   <= exp_pc_i;
`endif
    end
  end

  assign exp_ready_o       = (state_q == S_IDLE) && !full;
  assign busy_o            = (state_q == S_RUN);
  assign done_o            = (state_q == S_DONE) || (state_q == S_TIMEOUT);
  assign timeout_o         = (state_q == S_TIMEOUT);
  assign pass_o            = done_o && (fail_cnt_q == '0) && !timeout_o;
  assign fail_o            = done_o && !pass_o;
  assign pass_count_o      = pass_cnt_q;
  assign fail_count_o      = fail_cnt_q;
  assign cycle_count_o     = cyc_cnt_q;
  assign first_fail_idx_o  = ff_idx_q;
  assign first_fail_data_o = ff_data_q;

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Self-checking bench for riscv_commit_checker: directed plan scenarios plus randomized runs
// scored against a queue-based model of the retirement rules.
module tb_riscv_commit_checker;
  localparam int DW = 32, DEPTH = 16, TO = 16, CW = 16, IW = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, exp_valid, exp_ready, start, clr, wb_valid;
  logic [4:0] exp_rd, wb_rd;
  logic [DW-1:0] exp_data, exp_pc, wb_data, wb_pc;
  logic busy, done, pass, fail, tmo;
  logic [CW-1:0] pcnt, fcnt, ccnt;
  logic [IW-1:0] fidx;
  logic [DW-1:0] fdata;

  int checks = 0, failures = 0;

  logic [4:0]    e_rd[$];
  logic [DW-1:0] e_data[$], e_pc[$];
  logic          w_v[$];
  logic [4:0]    w_rd[$];
  logic [DW-1:0] w_data[$], w_pc[$];

  int m_pass, m_fail, m_cyc, m_fidx;
  logic [DW-1:0] m_fdata;
  bit m_done, m_to;

  riscv_commit_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .exp_valid_i(exp_valid), .exp_ready_o(exp_ready), .exp_rd_i(exp_rd),
    .exp_data_i(exp_data), .exp_pc_i(exp_pc),
    .start_i(start), .clear_i(clr),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail), .timeout_o(tmo),
    .pass_count_o(pcnt), .fail_count_o(fcnt), .cycle_count_o(ccnt),
    .first_fail_idx_o(fidx), .first_fail_data_o(fdata)
  );

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset(); rst = 1; tick(); tick(); rst = 0; endtask
  task automatic do_clear(); clr = 1; tick(); clr = 0; endtask

  task automatic clear_scn();
    e_rd.delete(); e_data.delete(); e_pc.delete();
    w_v.delete(); w_rd.delete(); w_data.delete(); w_pc.delete();
  endtask

  task automatic add_exp(input logic [4:0] rd, input logic [DW-1:0] d, input logic [DW-1:0] pc);
    e_rd.push_back(rd); e_data.push_back(d); e_pc.push_back(pc);
  endtask

  task automatic add_wb(input logic v, input logic [4:0] rd, input logic [DW-1:0] d, input logic [DW-1:0] pc);
    w_v.push_back(v); w_rd.push_back(rd); w_data.push_back(d); w_pc.push_back(pc);
  endtask

  task automatic load_all();
    for (int i = 0; i < e_rd.size(); i++) begin
      exp_valid = 1; exp_rd = e_rd[i]; exp_data = e_data[i]; exp_pc = e_pc[i];
      tick();
    end
    exp_valid = 0;
  endtask

  task automatic drive_wb();
    start = 1; tick(); start = 0;
    for (int i = 0; i < w_v.size(); i++) begin
      wb_valid = w_v[i]; wb_rd = w_rd[i]; wb_data = w_data[i]; wb_pc = w_pc[i];
      tick();
    end
    wb_valid = 0;
  endtask

  // Reference: pop a queue of expected writes for every non-x0 retire, count idle gaps.
  task automatic model_run();
    int ptr, idle;
    bit run, ok;
    ptr = 0; idle = 0; run = 1;
    m_pass = 0; m_fail = 0; m_cyc = 0; m_fidx = 0; m_fdata = '0; m_done = 0; m_to = 0;
    if (e_rd.size() == 0) begin run = 0; m_done = 1; end
    for (int i = 0; i < w_v.size(); i++) begin
      if (run) begin
        m_cyc++;
        if (w_v[i] && w_rd[i] != 5'd0) begin
          ok = (w_rd[i] == e_rd[ptr]) && (w_data[i] == e_data[ptr]);
`ifdef RISCV_CHECKER_PC_CHECK_EN
          ok = ok && (w_pc[i] == e_pc[ptr]);
`endif
          if (ok) m_pass++;
          else begin
            if (m_fail == 0) begin m_fidx = ptr; m_fdata = w_data[i]; end
            m_fail++;
          end
          ptr++; idle = 0;
          if (ptr == e_rd.size()) begin run = 0; m_done = 1; end
        end else begin
          idle++;
          if (idle == TO) begin run = 0; m_done = 1; m_to = 1; end
        end
      end
    end
  endtask

  task automatic plan_load();
    logic [4:0]    rds[8] = '{5'd6, 5'd7, 5'd5, 5'd14, 5'd17, 5'd20, 5'd23, 5'd26};
    logic [DW-1:0] ds[8]  = '{32'h11, 32'hFFFFFFFF, 32'h9C, 32'h1F, 32'h00900000, 32'h0, 32'h18, 32'h1F};
    clear_scn();
    for (int i = 0; i < 8; i++) add_exp(rds[i], ds[i], DW'(32'h100 + 4 * i));
  endtask

  task automatic test_reset();
    logic [3*CW+IW+DW+6-1:0] got, exp;
    do_reset();
    got = {exp_ready, busy, done, pass, fail, tmo, pcnt, fcnt, ccnt, fidx, fdata};
    exp = '0; exp[3*CW+IW+DW+5] = 1'b1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_outputs got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_plan_pass();
    do_clear(); plan_load(); load_all();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 8; i++) begin
      wb_valid = 1; wb_rd = e_rd[i]; wb_data = e_data[i]; wb_pc = e_pc[i];
      tick();
      if (i == 6) begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL plan_pass_early_done got=%0b exp=0", done); end
      end
    end
    wb_valid = 0;
    checks++;
    if ({done, pass, fail} !== 3'b110) begin failures++; $display("FAIL plan_pass_flags got=%b exp=110", {done, pass, fail}); end
    checks++;
    if ({pcnt, fcnt, ccnt} !== {16'd8, 16'd0, 16'd8}) begin
      failures++; $display("FAIL plan_pass_counts got=%0d/%0d/%0d exp=8/0/8", pcnt, fcnt, ccnt);
    end
  endtask

  task automatic test_plan_fail();
    do_clear(); plan_load(); load_all();
    for (int i = 0; i < 8; i++) add_wb(1, e_rd[i], (i == 2) ? 32'h9D : e_data[i], e_pc[i]);
    drive_wb();
    checks++;
    if ({done, fail, pass} !== 3'b110) begin failures++; $display("FAIL plan_fail_flags got=%b exp=110", {done, fail, pass}); end
    checks++;
    if ({pcnt, fcnt} !== {16'd7, 16'd1}) begin failures++; $display("FAIL plan_fail_counts got=%0d/%0d exp=7/1", pcnt, fcnt); end
    checks++;
    if (fidx !== IW'(2) || fdata !== 32'h9D) begin
      failures++; $display("FAIL plan_fail_capture got=%0d/%0h exp=2/9d", fidx, fdata);
    end
  endtask

  task automatic test_x0_ignored();
    do_clear(); clear_scn();
    add_exp(5'd3, 32'hA, 32'h0); add_exp(5'd4, 32'hB, 32'h4); add_exp(5'd5, 32'hC, 32'h8);
    load_all();
    add_wb(1, 5'd0, 32'hDEAD, 32'h0); add_wb(1, 5'd3, 32'hA, 32'h0);
    add_wb(1, 5'd0, 32'hBEEF, 32'h0); add_wb(1, 5'd0, 32'h1, 32'h0);
    add_wb(1, 5'd4, 32'hB, 32'h4);    add_wb(1, 5'd0, 32'h2, 32'h0);
    add_wb(1, 5'd5, 32'hC, 32'h8);
    drive_wb();
    checks++;
    if ({done, pass} !== 2'b11 || pcnt !== 16'd3 || ccnt !== 16'd7) begin
      failures++; $display("FAIL x0_ignored got=%b/%0d/%0d exp=11/3/7", {done, pass}, pcnt, ccnt);
    end
  endtask

  task automatic test_timeout();
    do_clear(); clear_scn();
    add_exp(5'd1, 32'h5, 32'h0); add_exp(5'd2, 32'h6, 32'h4);
    load_all();
    start = 1; tick(); start = 0;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h5; wb_pc = 32'h0; tick(); wb_valid = 0;
    repeat (TO - 1) tick();
    checks++;
    if (tmo !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_early got=%b exp=01", {tmo, busy}); end
    tick();
    checks++;
    if ({tmo, fail, done, pass} !== 4'b1110 || pcnt !== 16'd1) begin
      failures++; $display("FAIL timeout_fire got=%b/%0d exp=1110/1", {tmo, fail, done, pass}, pcnt);
    end
  endtask

  task automatic test_full_and_empty();
    do_clear(); clear_scn();
    for (int i = 0; i < DEPTH; i++) add_exp(5'(i + 1), DW'(i * 3), DW'(i * 4));
    load_all();
    checks++;
    if (exp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", exp_ready); end
    exp_valid = 1; exp_rd = 5'd31; exp_data = 32'h77; tick(); exp_valid = 0;
    for (int i = 0; i < DEPTH; i++) add_wb(1, e_rd[i], e_data[i], e_pc[i]);
    drive_wb();
    checks++;
    if ({done, pass} !== 2'b11 || pcnt !== 16'(DEPTH)) begin
      failures++; $display("FAIL full_run got=%b/%0d exp=11/%0d", {done, pass}, pcnt, DEPTH);
    end
    do_clear();
    start = 1; tick(); start = 0;
    checks++;
    if ({done, pass, busy, ccnt} !== {3'b110, 16'd0}) begin
      failures++; $display("FAIL empty_start got=%b/%0d exp=110/0", {done, pass, busy}, ccnt);
    end
  endtask

  task automatic test_load_with_start();
    do_clear();
    exp_valid = 1; exp_rd = 5'd9; exp_data = 32'h1234; exp_pc = 32'h40; start = 1;
    tick(); exp_valid = 0; start = 0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL load_start_busy got=%b exp=1", busy); end
    wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h1234; wb_pc = 32'h40; tick(); wb_valid = 0;
    checks++;
    if ({done, pass} !== 2'b11 || pcnt !== 16'd1) begin
      failures++; $display("FAIL load_start_run got=%b/%0d exp=11/1", {done, pass}, pcnt);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3*CW+IW+DW+6-1:0] got, exp;
    do_clear(); clear_scn();
    add_exp(5'd2, 32'h1, 32'h0); add_exp(5'd3, 32'h2, 32'h4); add_exp(5'd4, 32'h3, 32'h8);
    load_all();
    start = 1; tick(); start = 0;
    wb_valid = 1; wb_rd = 5'd2; wb_data = 32'hFF; wb_pc = 32'h0; tick(); wb_valid = 0;
    checks++;
    if (fcnt !== 16'd1 || fdata !== 32'hFF) begin failures++; $display("FAIL midrun_prefail got=%0d/%0h exp=1/ff", fcnt, fdata); end
    rst = 1; tick(); rst = 0;
    got = {exp_ready, busy, done, pass, fail, tmo, pcnt, fcnt, ccnt, fidx, fdata};
    exp = '0; exp[3*CW+IW+DW+5] = 1'b1;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midrun_reset got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_pc_check();
    do_clear(); clear_scn();
    add_exp(5'd6, 32'h11, 32'h4); load_all();
    add_wb(1, 5'd6, 32'h11, 32'h8);
    drive_wb();
    checks++;
`ifdef RISCV_CHECKER_PC_CHECK_EN
    if ({done, fail} !== 2'b11 || fcnt !== 16'd1) begin
      failures++; $display("FAIL pc_check got=%b/%0d exp=11/1", {done, fail}, fcnt);
    end
`else
    if ({done, pass} !== 2'b11 || fcnt !== 16'd0) begin
      failures++; $display("FAIL pc_check got=%b/%0d exp=11/0", {done, pass}, fcnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int n, k, gap, kind;
      bit trunc, m_pass_o;
      logic [4:0] rd;
      logic [DW-1:0] d, pc;
      do_clear(); clear_scn();
      n = $urandom_range(DEPTH, 1);
      trunc = ($urandom_range(5, 0) == 0);
      k = trunc ? $urandom_range(n - 1, 0) : n;
      for (int i = 0; i < n; i++) add_exp(5'($urandom_range(31, 1)), $urandom, $urandom);
      for (int i = 0; i < k; i++) begin
        gap = $urandom_range(3, 0);
        repeat (gap) begin
          if ($urandom_range(1, 0) == 1) add_wb(1, 5'd0, $urandom, $urandom);
          else add_wb(0, 5'($urandom_range(31, 0)), $urandom, $urandom);
        end
        rd = e_rd[i]; d = e_data[i]; pc = e_pc[i];
        kind = $urandom_range(7, 0);
        case (kind)
          0: d = d ^ (DW'(1) << $urandom_range(DW - 1, 0));
          1: rd = 5'((int'(rd) % 31) + 1);
          2: pc = pc + DW'(4);
          default: ;
        endcase
        add_wb(1, rd, d, pc);
      end
      repeat (trunc ? TO + 4 : 2) add_wb(0, 5'd0, '0, '0);
      load_all(); drive_wb(); model_run();
      m_pass_o = m_done && m_fail == 0 && !m_to;
      checks++;
      if ({done, tmo, pass, fail} !== {m_done, m_to, m_pass_o, m_done && !m_pass_o}) begin
        failures++; $display("FAIL rand_flags it=%0d got=%b exp=%b", it, {done, tmo, pass, fail},
                             {m_done, m_to, m_pass_o, m_done && !m_pass_o});
      end
      checks++;
      if ({pcnt, fcnt, ccnt} !== {CW'(m_pass), CW'(m_fail), CW'(m_cyc)}) begin
        failures++; $display("FAIL rand_counts it=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, pcnt, fcnt, ccnt, m_pass, m_fail, m_cyc);
      end
      checks++;
      if (fidx !== IW'(m_fidx) || fdata !== m_fdata) begin
        failures++; $display("FAIL rand_capture it=%0d got=%0d/%0h exp=%0d/%0h", it, fidx, fdata, m_fidx, m_fdata);
      end
      do_clear();
      checks++;
      if ({exp_ready, done, busy, pcnt, fcnt} !== {3'b100, 32'd0}) begin
        failures++; $display("FAIL rand_clear it=%0d got=%b/%0d/%0d exp=100/0/0", it, {exp_ready, done, busy}, pcnt, fcnt);
      end
    end
  endtask

  initial begin
    rst = 1; exp_valid = 0; exp_rd = '0; exp_data = '0; exp_pc = '0;
    start = 0; clr = 0; wb_valid = 0; wb_rd = '0; wb_data = '0; wb_pc = '0;
    test_reset();
    test_plan_pass();
    test_plan_fail();
    test_x0_ignored();
    test_timeout();
    test_full_and_empty();
    test_load_with_start();
    test_reset_mid_run();
    test_pc_check();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
